// File: rtl/imem_ctrl.sv
// imem SRAM initiator: loader word writes plus flow-controlled burst reads to the FIR datapath.
// Optional write-verify readback is built when IMEM_CTRL_VERIFY_EN is defined (adds err_cnt).
//   state   | meaning
//   S_IDLE  | accepting writes, waiting for rd_start
//   S_READ  | issuing burst reads, up to two words outstanding
//   S_DRAIN | all reads issued, emptying in-flight word and FIFO
module imem_ctrl #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
`ifdef IMEM_CTRL_VERIFY_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic              alive;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_rem;
    logic              rd_inflight;
    logic [DATA_W-1:0] fifo0;
    logic [DATA_W-1:0] fifo1;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        buf_cnt;
    logic [1:0]        occ;
    logic              idle;
    logic              start;
    logic              wr_go;
    logic              pop;
    logic              issue;
    logic              vfy_rd;

    assign idle      = (state == S_IDLE);
    assign rd_busy   = ~idle;
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = rd_ptr ? fifo1 : fifo0;
    assign pop       = out_valid & out_ready;
    assign occ       = buf_cnt + {1'b0, rd_inflight};

    // alive keeps wr_ready low while reset is asserted even though state sits in IDLE
    assign start    = idle & alive & rd_start & (rd_len != '0) & ~vfy_rd;
    assign wr_ready = idle & alive & ~start & ~vfy_rd;
    assign wr_go    = wr_valid & wr_ready;

    // counting the word leaving this cycle lets the 2-entry FIFO sustain one word per cycle
    assign issue = (state == S_READ) & ((occ < 2'd2) | ((occ == 2'd2) & pop));

`ifdef IMEM_CTRL_VERIFY_EN
    logic              vfy_cmp;
    logic [ADDR_W-1:0] vfy_addr;
    logic [DATA_W-1:0] vfy_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vfy_rd   <= 1'b0;
            vfy_cmp  <= 1'b0;
            vfy_addr <= '0;
            vfy_data <= '0;
            err_cnt  <= 16'd0;
        end else begin
            vfy_rd  <= wr_go;
            vfy_cmp <= vfy_rd;
            if (wr_go) begin
                vfy_addr <= wr_addr;
                vfy_data <= wr_data;
            end
            if (vfy_cmp && (mem_q != vfy_data) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign vfy_rd = 1'b0;
`endif

    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_a   = '0;
        mem_d   = '0;
        if (issue) begin
            mem_cen = 1'b0;
            mem_a   = rd_addr;
`ifdef IMEM_CTRL_VERIFY_EN
        end else if (vfy_rd) begin
            mem_cen = 1'b0;
            mem_a   = vfy_addr;
`endif
        end else if (wr_go) begin
            mem_cen = 1'b0;
            mem_wen = 1'b0;
            mem_a   = wr_addr;
            mem_d   = wr_data;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  if (issue && (rd_rem == LEN_W'(1))) state_nx = S_DRAIN;
            S_DRAIN: if (!rd_inflight && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop)))
                         state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            alive       <= 1'b0;
            rd_addr     <= '0;
            rd_rem      <= '0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nx;
            alive       <= 1'b1;
            rd_inflight <= issue;
            if (start) begin
                rd_addr <= rd_base;
                rd_rem  <= rd_len;
            end else if (issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_rem  <= rd_rem - LEN_W'(1);
            end
        end
    end

    // word read last cycle lands in the FIFO at this edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo0   <= '0;
            fifo1   <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (rd_inflight) begin
                if (wr_ptr) fifo1 <= mem_q;
                else        fifo0 <= mem_q;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, rd_inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: SRAM behavioural model, memory-content reference and burst scoreboard.
module tb_imem_ctrl;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 15;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HOLD_ADDR = 100;
    localparam logic [DATA_W-1:0] HOLD_DATA = 16'hBEEF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_start = 1'b0;
    logic [ADDR_W-1:0] rd_base = '0;
    logic [LEN_W-1:0]  rd_len = '0;
    logic              rd_busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q = '0;
`ifdef IMEM_CTRL_VERIFY_EN
    logic [15:0]       err_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] sram [DEPTH];
    bit stuck0 = 1'b0;

    imem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
`ifdef IMEM_CTRL_VERIFY_EN
        .err_cnt(err_cnt),
`endif
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cen == 1'b0) begin
            if (mem_wen == 1'b0) sram[mem_a] <= stuck0 ? (mem_d & 16'hFFFE) : mem_d;
            else                 mem_q <= sram[mem_a];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic do_write(input int addr, input logic [DATA_W-1:0] data);
        int t;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = ADDR_W'(addr); wr_data = data;
        #1;
        t = 0;
        while (wr_ready !== 1'b1 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (wr_ready !== 1'b1 || mem_cen !== 1'b0 || mem_wen !== 1'b0 ||
            mem_a !== ADDR_W'(addr) || mem_d !== data) begin
            n_err++;
            $display("FAIL write a=%0d: wr_ready=%b cen=%b wen=%b mem_a=%0d mem_d=%0d, required 1 0 0 %0d %0d",
                     addr, wr_ready, mem_cen, mem_wen, mem_a, mem_d, addr, data);
        end
        ref_mem[addr] = data;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // mode: 0 out_ready held high, 1 toggling, 2 random; abort_after>0 resets after that many words
    task automatic run_burst(input int base, input int len, input int mode,
                             input bit hold_wr, input int abort_after);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] held_data;
        int issued, accepted, c, first_v;
        bit held, rdy;
        for (int k = 0; k < len; k++) exp_q.push_back(ref_mem[(base + k) % DEPTH]);
        @(negedge clk);
        rd_start = 1'b1; rd_base = ADDR_W'(base); rd_len = LEN_W'(len); out_ready = 1'b0;
        if (hold_wr) begin
            wr_valid = 1'b1; wr_addr = ADDR_W'(HOLD_ADDR); wr_data = HOLD_DATA;
        end
        #1;
        if (hold_wr) begin
            n_cmp++;
            if (wr_ready !== 1'b0 || mem_cen !== 1'b1) begin
                n_err++;
                $display("FAIL start_vs_write: wr_ready=%b mem_cen=%b, required 0 1", wr_ready, mem_cen);
            end
        end
        issued = 0; accepted = 0; c = 0; first_v = 0; held = 1'b0; held_data = '0;
        while (accepted < len && c < 400) begin
            @(negedge clk);
            c++;
            rd_start = 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = c[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            #1;
            n_cmp++;
            if (rd_busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy c=%0d: rd_busy=%b, required 1", c, rd_busy);
            end
            if (hold_wr) begin
                n_cmp++;
                if (wr_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL wr_blocked c=%0d: wr_ready=%b, required 0", c, wr_ready);
                end
            end
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held_data) begin
                    n_err++;
                    $display("FAIL hold c=%0d: out_valid=%b out_data=%0d, required 1 %0d",
                             c, out_valid, out_data, held_data);
                end
            end
            if (out_valid === 1'b1 && first_v == 0) first_v = c;
            if (mem_cen === 1'b0) begin
                n_cmp++;
                if (mem_wen !== 1'b1 || mem_a !== ADDR_W'((base + issued) % DEPTH)) begin
                    n_err++;
                    $display("FAIL rd_addr #%0d: wen=%b mem_a=%0d, required 1 %0d",
                             issued, mem_wen, mem_a, (base + issued) % DEPTH);
                end
                issued++;
            end
            if (out_valid === 1'b1 && rdy) begin
                n_cmp++;
                if (out_data !== exp_q[accepted]) begin
                    n_err++;
                    $display("FAIL word #%0d: out_data=%0d, required %0d", accepted, out_data, exp_q[accepted]);
                end
                accepted++;
            end
            held = (out_valid === 1'b1) && !rdy;
            held_data = out_data;
            n_cmp++;
            if (issued - accepted > 2 || issued > len) begin
                n_err++;
                $display("FAIL lookahead c=%0d: issued=%0d accepted=%0d, required ahead<=2 issued<=%0d",
                         c, issued, accepted, len);
            end
            if (abort_after != 0 && accepted == abort_after) break;
        end
        if (c >= 400) begin
            n_cmp++; n_err++;
            $display("FAIL burst_timeout: accepted=%0d, required %0d", accepted, len);
        end
        if (abort_after != 0) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || rd_busy !== 1'b0 || mem_cen !== 1'b1 || wr_ready !== 1'b0) begin
                n_err++;
                $display("FAIL abort: out_valid=%b rd_busy=%b mem_cen=%b wr_ready=%b, required 0 0 1 0",
                         out_valid, rd_busy, mem_cen, wr_ready);
            end
            out_ready = 1'b0;
            return;
        end
        n_cmp++;
        if (first_v != 3 || issued != len) begin
            n_err++;
            $display("FAIL latency: first valid c=%0d issued=%0d, required 3 %0d", first_v, issued, len);
        end
        if (mode == 0) begin
            n_cmp++;
            if (c != len + 2) begin
                n_err++;
                $display("FAIL no_bubble: last word c=%0d, required %0d", c, len + 2);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (rd_busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL end: rd_busy=%b out_valid=%b, required 0 0", rd_busy, out_valid);
        end
        if (hold_wr) begin
            n_cmp++;
            if (wr_ready !== 1'b1 || mem_cen !== 1'b0 || mem_wen !== 1'b0 || mem_a !== ADDR_W'(HOLD_ADDR)) begin
                n_err++;
                $display("FAIL late_write: wr_ready=%b cen=%b wen=%b mem_a=%0d, required 1 0 0 %0d",
                         wr_ready, mem_cen, mem_wen, mem_a, HOLD_ADDR);
            end
            ref_mem[HOLD_ADDR] = HOLD_DATA;
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b1; wr_addr = 14'd77; wr_data = 16'h1234;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_a !== '0 || mem_d !== '0 ||
            out_valid !== 1'b0 || out_data !== '0 || rd_busy !== 1'b0 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset: cen=%b wen=%b a=%0d d=%0d ov=%b od=%0d busy=%b wr_ready=%b, required 1 1 0 0 0 0 0 0",
                     mem_cen, mem_wen, mem_a, mem_d, out_valid, out_data, rd_busy, wr_ready);
        end
`ifdef IMEM_CTRL_VERIFY_EN
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_err_cnt: err_cnt=%0d, required 0", err_cnt);
        end
`endif
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1 || mem_cen !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: wr_ready=%b mem_cen=%b, required 1 1", wr_ready, mem_cen);
        end
    endtask

    task automatic test_single();
        do_write(1, 16'd350);
        run_burst(1, 1, 0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
`ifdef IMEM_CTRL_VERIFY_EN
        for (int i = 0; i < 16; i++) do_write(i, DATA_W'(100 + i));
`else
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(100 + i);
            #1;
            n_cmp++;
            if (wr_ready !== 1'b1 || mem_cen !== 1'b0 || mem_wen !== 1'b0 ||
                mem_a !== ADDR_W'(i) || mem_d !== DATA_W'(100 + i)) begin
                n_err++;
                $display("FAIL stream_write #%0d: wr_ready=%b cen=%b wen=%b a=%0d d=%0d, required 1 0 0 %0d %0d",
                         i, wr_ready, mem_cen, mem_wen, mem_a, mem_d, i, 100 + i);
            end
            ref_mem[i] = DATA_W'(100 + i);
        end
        @(negedge clk);
        wr_valid = 1'b0;
`endif
        run_burst(0, 16, 0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_burst(0, 16, 1, 1'b0, 0);
        run_burst(0, 16, 2, 1'b0, 0);
    endtask

    task automatic test_wrap();
        do_write(16382, DATA_W'($urandom));
        do_write(16383, DATA_W'($urandom));
        do_write(0, DATA_W'($urandom));
        do_write(1, DATA_W'($urandom));
        run_burst(16382, 4, 2, 1'b0, 0);
    endtask

    task automatic test_start_vs_write();
        run_burst(0, 8, 0, 1'b1, 0);
        run_burst(HOLD_ADDR, 1, 0, 1'b0, 0);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        rd_start = 1'b1; rd_base = 14'd5; rd_len = '0;
        wr_valid = 1'b1; wr_addr = 14'd300; wr_data = 16'h0F0F;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1 || mem_cen !== 1'b0 || mem_wen !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_write: wr_ready=%b cen=%b wen=%b, required 1 0 0", wr_ready, mem_cen, mem_wen);
        end
        ref_mem[300] = 16'h0F0F;
        @(negedge clk);
        rd_start = 1'b0; wr_valid = 1'b0;
        #1;
        n_cmp++;
        if (rd_busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_busy: rd_busy=%b, required 0", rd_busy);
        end
        run_burst(300, 1, 0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_burst();
        run_burst(0, 16, 0, 1'b0, 5);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1 || rd_busy !== 1'b0) begin
            n_err++;
            $display("FAIL after_abort: wr_ready=%b rd_busy=%b, required 1 0", wr_ready, rd_busy);
        end
        run_burst(0, 16, 2, 1'b0, 0);
    endtask

    task automatic test_random();
        int base, len;
        for (int i = 0; i < 64; i++) do_write(200 + i, DATA_W'($urandom));
        for (int j = 0; j < 10; j++) begin
            len  = $urandom_range(1, 20);
            base = 200 + $urandom_range(0, 64 - len);
            run_burst(base, len, 2, 1'b0, 0);
        end
    endtask

`ifdef IMEM_CTRL_VERIFY_EN
    task automatic test_verify();
        stuck0 = 1'b1;
        do_write(500, 16'd351);
        #1;
        n_cmp++;
        if (mem_cen !== 1'b0 || mem_wen !== 1'b1 || mem_a !== 14'd500 || wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL verify_read: cen=%b wen=%b a=%0d wr_ready=%b, required 0 1 500 0",
                     mem_cen, mem_wen, mem_a, wr_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL verify_err1: err_cnt=%0d, required 1", err_cnt);
        end
        do_write(501, 16'd350);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL verify_err_hold: err_cnt=%0d, required 1", err_cnt);
        end
        stuck0 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_start_vs_write();
        test_zero_len();
        test_reset_mid_burst();
        test_random();
`ifdef IMEM_CTRL_VERIFY_EN
        test_verify();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
